// File: rtl/ram_channel_client.sv
`default_nettype none
// ============================================================================
// Module   : ram_channel_client
// Purpose  : Load/store initiator between the CPU memory stage and one read
//            channel plus one write channel of the SRAM arbiter. Takes one
//            request at a time over valid/ready, runs the edge-triggered
//            size-strobe protocol on the selected channel, and returns a
//            single-cycle response with sign/zero-extended load data.
//            A watchdog turns a stuck channel into an error response.
// Ports    : clk, reset_n          clock, asynchronous active-low reset
//            req_*                 CPU request (valid/ready handshake)
//            resp_*                one-cycle response pulse + held data/error
//            rd_*                  read channel (address, size strobe, data, ready)
//            wr_*                  write channel (address, size strobe, data, ready)
// Revision : 1.0 - initial release
// ============================================================================
module ram_channel_client #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  // CPU request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  // CPU response side
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  // read channel
  output logic [31:0] rd_address,
  output logic [1:0]  rd_sig_read,
  input  logic [31:0] rd_data,
  input  logic        rd_is_ready,
  // write channel
  output logic [31:0] wr_address,
  output logic [1:0]  wr_sig_write,
  output logic [31:0] wr_data,
  input  logic        wr_is_ready
);

  localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_STROBE = 3'd2,
    S_GUARD  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [15:0] cnt_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;
  logic [31:0] rd_address_q;
  logic [1:0]  rd_sig_q;
  logic [31:0] wr_address_q;
  logic [1:0]  wr_sig_q;
  logic [31:0] wr_data_q;

  logic        sel_ready;
  logic [31:0] ld_ext_d;

  // Only the channel that owns the current request is watched.
  assign sel_ready = write_q ? wr_is_ready : rd_is_ready;

  // Load extension; upper channel bits are ignored for byte/half loads.
  always_comb begin
    ld_ext_d = rd_data;
    case (size_q)
      2'd1:    ld_ext_d = {{24{~unsigned_q & rd_data[7]}}, rd_data[7:0]};
      2'd2:    ld_ext_d = {{16{~unsigned_q & rd_data[15]}}, rd_data[15:0]};
      default: ld_ext_d = rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      cnt_q        <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
      rd_address_q <= 32'd0;
      rd_sig_q     <= 2'd0;
      wr_address_q <= 32'd0;
      wr_sig_q     <= 2'd0;
      wr_data_q    <= 32'd0;
    end else begin
      // The response is a single-cycle pulse; data/error stay held.
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            if (req_size == 2'd0) begin
              // Illegal size: answer immediately, no channel traffic.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q <= S_ARB;
              if (req_write) begin
                wr_address_q <= req_address;
                wr_data_q    <= req_wdata;
              end else begin
                rd_address_q <= req_address;
              end
            end
          end
        end
        S_ARB: begin
          // Wait for the channel to drain anything still in flight
          // (including an operation we previously abandoned on timeout).
          if (sel_ready) begin
            state_q <= S_STROBE;
            if (write_q) wr_sig_q <= size_q;
            else         rd_sig_q <= size_q;
          end
        end
        S_STROBE: begin
          rd_sig_q <= 2'd0;
          wr_sig_q <= 2'd0;
          state_q  <= S_GUARD;
        end
        S_GUARD: begin
          // The arbiter may still report ready from before it saw the
          // strobe, so ready is not trusted in this cycle.
          cnt_q   <= 16'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (sel_ready) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= write_q ? 32'd0 : ld_ext_d;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_error   = resp_error_q;
  assign rd_address   = rd_address_q;
  assign rd_sig_read  = rd_sig_q;
  assign wr_address   = wr_address_q;
  assign wr_sig_write = wr_sig_q;
  assign wr_data      = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_channel_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_channel_client
// Purpose  : Self-checking bench for ram_channel_client (TIMEOUT_CYCLES=8).
//            A vector table drives load/store/illegal/timeout transactions
//            through a small channel model; reset-abort is hand-written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_channel_client;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] rd_address;
  logic [1:0]  rd_sig_read;
  logic [31:0] rd_data = 32'd0;
  logic        rd_is_ready = 1'b1;
  logic [31:0] wr_address;
  logic [1:0]  wr_sig_write;
  logic [31:0] wr_data;
  logic        wr_is_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  ram_channel_client #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .rd_address   (rd_address),
    .rd_sig_read  (rd_sig_read),
    .rd_data      (rd_data),
    .rd_is_ready  (rd_is_ready),
    .wr_address   (wr_address),
    .wr_sig_write (wr_sig_write),
    .wr_data      (wr_data),
    .wr_is_ready  (wr_is_ready)
  );

  always #5 clk = ~clk;

  // stall : cycles after accept that the channel stays busy before ARB can go
  // delay : busy WAIT cycles after the strobe before ready returns (-1 = never)
  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          stall;
    int          delay;
    int          lat_min;
    int          lat_max;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_sel_ready(input logic wr, input logic val);
    if (wr) wr_is_ready = val;
    else    rd_is_ready = val;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    int          strobe_n;
    int          sig_cycles;
    int          raise_at;
    int          lat;
    logic [1:0]  sig_val;
    logic [1:0]  sel_sig;
    logic        other_sig;
    logic        got_resp;
    logic        ready_in_resp;
    logic        addr_ok;
    logic [31:0] r;
    logic        e;
    string       tag;
    tag = $sformatf("v%0d", idx);
    strobe_n = -1; sig_cycles = 0; raise_at = -1; lat = -1;
    sig_val = 2'd0; other_sig = 1'b0; got_resp = 1'b0; ready_in_resp = 1'b1;
    addr_ok = 1'b0; r = 32'd0; e = 1'b0;

    @(negedge clk);
    chk({tag, "_accept_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.write; req_size = v.size;
    req_unsigned = v.uns; req_address = v.addr; req_wdata = v.wdata;
    rd_data = 32'hA5A5_A5A5;
    set_sel_ready(v.write, (v.stall == 0));
    set_sel_ready(~v.write, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (n <= 60 && !got_resp) begin
      sel_sig = v.write ? wr_sig_write : rd_sig_read;
      if (sel_sig != 2'd0) begin
        sig_cycles++;
        sig_val = sel_sig;
        if (strobe_n < 0) begin
          strobe_n = n;
          addr_ok = v.write ? (wr_address == v.addr && wr_data == v.wdata)
                            : (rd_address == v.addr);
        end
        set_sel_ready(v.write, 1'b0);
        raise_at = (v.delay < 0) ? -1 : n + 1 + v.delay;
      end
      if ((v.write ? rd_sig_read : wr_sig_write) != 2'd0) other_sig = 1'b1;
      if (v.stall > 0 && n == v.stall + 1 && strobe_n < 0) set_sel_ready(v.write, 1'b1);
      if (n == raise_at) begin
        set_sel_ready(v.write, 1'b1);
        rd_data = v.ram;
      end
      if (resp_valid) begin
        got_resp = 1'b1; lat = n; r = resp_rdata; e = resp_error;
        ready_in_resp = req_ready;
      end
      @(negedge clk);
      n++;
    end

    chk({tag, "_resp_seen"}, {31'd0, got_resp}, 32'd1);
    checks++;
    if (lat < v.lat_min || lat > v.lat_max) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d..%0d", tag, lat, v.lat_min, v.lat_max);
    end
    chk({tag, "_rdata"}, r, v.exp_rdata);
    chk({tag, "_error"}, {31'd0, e}, {31'd0, v.exp_err});
    chk({tag, "_ready_in_resp"}, {31'd0, ready_in_resp}, 32'd0);
    chk({tag, "_strobe_cycles"}, sig_cycles, (v.size != 2'd0) ? 32'd1 : 32'd0);
    chk({tag, "_other_sig"}, {31'd0, other_sig}, 32'd0);
    if (v.size != 2'd0) begin
      chk({tag, "_strobe_val"}, {30'd0, sig_val}, {30'd0, v.size});
      chk({tag, "_strobe_at"}, strobe_n, v.stall + 2);
      chk({tag, "_addr_data"}, {31'd0, addr_ok}, 32'd1);
    end
    // one cycle after the pulse: valid gone, data/error held
    chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_rdata_hold"}, resp_rdata, v.exp_rdata);
    chk({tag, "_error_hold"}, {31'd0, resp_error}, {31'd0, v.exp_err});
  endtask

  initial begin
    //         wr    sz    uns   addr          wdata          ram            exp_rdata      err  stall dly lmin lmax
    vecs[0] = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h8001_7F02, 32'h8001_7F02, 1'b0, 0, 3, 7, 7};
    vecs[1] = '{1'b0, 2'd1, 1'b0, 32'h0000_0021, 32'h0,         32'h1234_5680, 32'hFFFF_FF80, 1'b0, 0, 1, 5, 5};
    vecs[2] = '{1'b0, 2'd1, 1'b1, 32'h0000_0021, 32'h0,         32'h1234_5680, 32'h0000_0080, 1'b0, 0, 1, 5, 5};
    vecs[3] = '{1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0,         32'hABCD_8001, 32'hFFFF_8001, 1'b0, 0, 2, 6, 6};
    vecs[4] = '{1'b0, 2'd2, 1'b1, 32'h0000_0044, 32'h0,         32'hFFFF_8001, 32'h0000_8001, 1'b0, 0, 1, 5, 5};
    vecs[5] = '{1'b1, 2'd2, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 0, 2, 6, 6};
    vecs[6] = '{1'b1, 2'd1, 1'b0, 32'h0000_0007, 32'h1122_3344, 32'h0,         32'h0,         1'b0, 0, 1, 5, 5};
    vecs[7] = '{1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         32'h0,         1'b1, 0, 1, 1, 2};
    // timeout: 8 WAIT cycles, then the next load stalls in ARB until ready
    vecs[8] = '{1'b0, 2'd3, 1'b0, 32'h0000_0200, 32'h0,         32'h0,         32'h0,         1'b1, 0, -1, 12, 12};
    vecs[9] = '{1'b0, 2'd1, 1'b0, 32'h0000_0300, 32'h0,         32'h0000_007F, 32'h0000_007F, 1'b0, 5, 1, 10, 10};

    // reset state
    #2;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_sigs", {28'd0, rd_sig_read, wr_sig_write}, 32'd0);
    chk("rst_addrs", rd_address | wr_address | wr_data, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // reset asserted while a load is waiting on the channel
    @(negedge clk);
    rd_is_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3;
    req_unsigned = 1'b0; req_address = 32'h0000_0444;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);                 // STROBE
    chk("abort_strobe", {30'd0, rd_sig_read}, 32'd3);
    rd_is_ready = 1'b0;
    repeat (3) @(negedge clk);      // GUARD, WAIT, WAIT
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {rd_address | wr_address | wr_data | resp_rdata}, 32'd0);
    chk("abort_flags", {27'd0, resp_valid, resp_error, rd_sig_read, wr_sig_write[0] | wr_sig_write[1]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      logic saw_resp;
      logic ready_low;
      saw_resp = 1'b0; ready_low = 1'b0;
      rd_is_ready = 1'b1;
      rd_data = 32'hFFFF_FFFF;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (resp_valid) saw_resp = 1'b1;
        if (!req_ready) ready_low = 1'b1;
      end
      chk("abort_no_resp", {31'd0, saw_resp}, 32'd0);
      chk("abort_idle", {31'd0, ready_low}, 32'd0);
    end

    // recovery after the aborted request
    run_vec('{1'b0, 2'd3, 1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 0, 1, 5, 5}, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute safety net
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
